// File: rtl/packet_assembler_pkg.sv
// eer_pkt_pkg: shared constants and types for the packet assembler slice.
// Optional build macro: PKT_CHECKSUM_EN appends an XOR checksum word to every packet.
package eer_pkt_pkg;
   localparam int WORD_WIDTH = 16;
   localparam int MAX_WORDS  = 9;
   localparam int IDX_W      = $clog2(MAX_WORDS);

   localparam logic [2:0] PKT_HB   = 3'd1;
   localparam logic [2:0] PKT_CHE  = 3'd2;
   localparam logic [2:0] PKT_MR   = 3'd3;
   localparam logic [2:0] PKT_DATA = 3'd4;

`ifdef PKT_CHECKSUM_EN
   localparam int CSUM_WORDS = 1;
`else
   localparam int CSUM_WORDS = 0;
`endif

   // Total words per packet type, checksum included when it is built in.
   localparam logic [4:0] LEN_HB   = 5'(6 + CSUM_WORDS);
   localparam logic [4:0] LEN_CHE  = 5'(8 + CSUM_WORDS);
   localparam logic [4:0] LEN_MR   = 5'(5 + CSUM_WORDS);
   localparam logic [4:0] LEN_DATA = 5'(6 + CSUM_WORDS);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   // One captured reward result; used for both the active and pending slots.
   typedef struct packed {
      logic [WORD_WIDTH-1:0] sourceId;
      logic [WORD_WIDTH-1:0] energyLeft;
      logic [WORD_WIDTH-1:0] qValue;
      logic [WORD_WIDTH-1:0] sourceHops;
      logic [WORD_WIDTH-1:0] destinationId;
      logic [2:0]            packetType;
      logic [WORD_WIDTH-1:0] chosenCh;
      logic [WORD_WIDTH-1:0] hopsFromCh;
   } pkt_fields_t;

   function automatic logic isValidType(input logic [2:0] t);
      return (t == PKT_HB) || (t == PKT_CHE) || (t == PKT_MR) || (t == PKT_DATA);
   endfunction
endpackage

// File: rtl/packet_assembler_if.sv
// packet_assembler_if: TX word stream from the assembler to the radio buffer.
// Handshake: a word transfers on a rising clk edge where tx_valid && tx_ready;
// while tx_valid is high and tx_ready low, tx_data/tx_last hold and tx_valid stays high.
interface packet_assembler_if;
   import eer_pkt_pkg::*;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  tx_last;
   logic [WORD_WIDTH-1:0] tx_data;

   modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
   modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/packet_assembler_word_mux.sv
// pkt_word_mux: selects the packet word for (type, index) and reports packet length.
// With PKT_CHECKSUM_EN defined the final index returns the XOR of all earlier words.
module pkt_word_mux
   import eer_pkt_pkg::*;
#(
   parameter logic [WORD_WIDTH-1:0] BCAST_ID = 16'hFFFF
) (
   input  pkt_fields_t           fields,
   input  logic [IDX_W-1:0]      idx,
   output logic [WORD_WIDTH-1:0] word,
   output logic [4:0]            len
);
   // Payload word for one index; indexes past the payload read as zero.
   function automatic logic [WORD_WIDTH-1:0] rawWord(input pkt_fields_t f,
                                                     input logic [4:0] l,
                                                     input logic [IDX_W-1:0] i);
      logic [WORD_WIDTH-1:0] w;
      w = '0;
      if (i == '0) begin
         w = {f.packetType, l, 8'h00};
      end else begin
         case (f.packetType)
            PKT_HB: case (i)
               4'd1: w = f.sourceId;
               4'd2: w = BCAST_ID;
               4'd3: w = f.sourceHops;
               4'd4: w = f.qValue;
               4'd5: w = f.energyLeft;
               default: w = '0;
            endcase
            PKT_CHE: case (i)
               4'd1: w = f.sourceId;
               4'd2: w = f.destinationId;
               4'd3: w = f.sourceHops;
               4'd4: w = f.qValue;
               4'd5: w = f.energyLeft;
               4'd6: w = f.chosenCh;
               4'd7: w = f.hopsFromCh;
               default: w = '0;
            endcase
            PKT_MR: case (i)
               4'd1: w = f.sourceId;
               4'd2: w = f.chosenCh;
               4'd3: w = f.qValue;
               4'd4: w = f.energyLeft;
               default: w = '0;
            endcase
            PKT_DATA: case (i)
               4'd1: w = f.sourceId;
               4'd2: w = f.destinationId;
               4'd3: w = f.hopsFromCh;
               4'd4: w = f.qValue;
               4'd5: w = f.energyLeft;
               default: w = '0;
            endcase
            default: w = '0;
         endcase
      end
      return w;
   endfunction

   // Length lookup by packet type; unsupported types report zero.
   always_comb begin
      len = 5'd0;
      case (fields.packetType)
         PKT_HB:   len = LEN_HB;
         PKT_CHE:  len = LEN_CHE;
         PKT_MR:   len = LEN_MR;
         PKT_DATA: len = LEN_DATA;
         default:  len = 5'd0;
      endcase
   end

`ifdef PKT_CHECKSUM_EN
   logic [WORD_WIDTH-1:0] csum;

   // Checksum covers every earlier word; unused indexes contribute zero.
   always_comb begin
      csum = '0;
      for (int i = 0; i < MAX_WORDS - 1; i++) begin
         csum = csum ^ rawWord(fields, len, IDX_W'(i));
      end
      word = (5'(idx) == len - 5'd1) ? csum : rawWord(fields, len, idx);
   end
`else
   // Plain word selection.
   always_comb begin
      word = rawWord(fields, len, idx);
   end
`endif
endmodule

// File: rtl/packet_assembler.sv
// packet_assembler: captures reward-stage results and streams them as TX words.
// One active packet plus a one-deep pending slot; a third capture is dropped.
// Optional build macro: PKT_CHECKSUM_EN (XOR checksum word, see pkt_word_mux).
module packet_assembler
   import eer_pkt_pkg::*;
#(
   parameter logic [WORD_WIDTH-1:0] BCAST_ID = 16'hFFFF
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  en,
   input  logic                  reward_done,
   input  logic [WORD_WIDTH-1:0] rSourceID,
   input  logic [WORD_WIDTH-1:0] rEnergyLeft,
   input  logic [WORD_WIDTH-1:0] rQValue,
   input  logic [WORD_WIDTH-1:0] rSourceHops,
   input  logic [WORD_WIDTH-1:0] rDestinationID,
   input  logic [2:0]            rPacketType,
   input  logic [WORD_WIDTH-1:0] rChosenCH,
   input  logic [WORD_WIDTH-1:0] rHopsFromCH,
   packet_assembler_if.master    tx,
   output logic                  busy,
   output logic                  sent,
   output logic                  drop,
   output state_t                dbgState
);
   state_t                state;
   pkt_fields_t           active;
   pkt_fields_t           pending;
   pkt_fields_t           capFields;
   pkt_fields_t           muxFields;
   logic                  pendFull;
   logic [IDX_W-1:0]      wordIdx;
   logic [IDX_W-1:0]      muxIdx;
   logic [WORD_WIDTH-1:0] muxWord;
   logic [4:0]            muxLen;
   logic                  muxLast;
   logic                  txValid;
   logic                  txLast;
   logic [WORD_WIDTH-1:0] txData;
   logic                  capValid;
   logic                  capBad;
   logic                  hs;
   logic                  lastHs;

   assign capFields = '{sourceId: rSourceID, energyLeft: rEnergyLeft, qValue: rQValue,
                        sourceHops: rSourceHops, destinationId: rDestinationID,
                        packetType: rPacketType, chosenCh: rChosenCH,
                        hopsFromCh: rHopsFromCH};
   assign capValid = en && reward_done && isValidType(rPacketType);
   assign capBad   = en && reward_done && !isValidType(rPacketType);
   assign hs       = txValid && tx.tx_ready;
   assign lastHs   = hs && txLast;

   // Choose which packet/index the word mux prepares for the next cycle.
   always_comb begin
      muxFields = active;
      muxIdx    = '0;
      if (state == IDLE) begin
         muxFields = capFields;
      end else if (txValid) begin
         muxIdx = wordIdx + IDX_W'(1);
      end
   end

   pkt_word_mux #(.BCAST_ID(BCAST_ID)) u_word_mux (
      .fields (muxFields),
      .idx    (muxIdx),
      .word   (muxWord),
      .len    (muxLen)
   );

   assign muxLast = (5'(muxIdx) == muxLen - 5'd1);

   // Packet FSM with registered TX outputs, pending-slot management and pulses.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         active   <= '0;
         pending  <= '0;
         pendFull <= 1'b0;
         wordIdx  <= '0;
         txValid  <= 1'b0;
         txData   <= '0;
         txLast   <= 1'b0;
         sent     <= 1'b0;
         drop     <= 1'b0;
      end else begin
         sent <= 1'b0;
         drop <= 1'b0;
         case (state)
            IDLE: begin
               if (capValid) begin
                  active  <= capFields;
                  wordIdx <= '0;
                  txValid <= 1'b1;
                  txData  <= muxWord;
                  txLast  <= muxLast;
                  state   <= SEND;
               end
               drop <= capBad;
            end
            SEND: begin
               if (lastHs) begin
                  // Packet done: promote the next one (after a gap cycle) or go idle.
                  sent    <= 1'b1;
                  txValid <= 1'b0;
                  txLast  <= 1'b0;
                  txData  <= '0;
                  if (pendFull) begin
                     active   <= pending;
                     pending  <= capFields;
                     pendFull <= capValid;
                  end else if (capValid) begin
                     active <= capFields;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  if (hs) begin
                     wordIdx <= wordIdx + IDX_W'(1);
                     txData  <= muxWord;
                     txLast  <= muxLast;
                  end else if (!txValid) begin
                     // Gap cycle after a promotion: present word 0 of the new packet.
                     wordIdx <= '0;
                     txValid <= 1'b1;
                     txData  <= muxWord;
                     txLast  <= muxLast;
                  end
                  if (capValid) begin
                     if (pendFull) begin
                        drop <= 1'b1;
                     end else begin
                        pending  <= capFields;
                        pendFull <= 1'b1;
                     end
                  end
               end
               if (capBad) begin
                  drop <= 1'b1;
               end
            end
         endcase
      end
   end

   assign tx.tx_valid = txValid;
   assign tx.tx_data  = txData;
   assign tx.tx_last  = txLast;
   assign busy        = (state == SEND) || pendFull;
   assign dbgState    = state;
endmodule

// File: tb/tb_packet_assembler.sv
// tb_packet_assembler: directed scenarios for packet_assembler.
// Honours PKT_CHECKSUM_EN by extending expected headers and appending the XOR word.
module tb_packet_assembler;
   import eer_pkt_pkg::*;

`ifdef PKT_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic        clk = 1'b0;
   logic        nrst;
   logic        en;
   logic        reward_done;
   logic [15:0] rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID;
   logic [2:0]  rPacketType;
   logic [15:0] rChosenCH, rHopsFromCH;
   logic        busy, sent, drop;
   state_t      dbgState;

   packet_assembler_if txIf ();

   packet_assembler #(.BCAST_ID(16'hFFFF)) dut (
      .clk            (clk),
      .nrst           (nrst),
      .en             (en),
      .reward_done    (reward_done),
      .rSourceID      (rSourceID),
      .rEnergyLeft    (rEnergyLeft),
      .rQValue        (rQValue),
      .rSourceHops    (rSourceHops),
      .rDestinationID (rDestinationID),
      .rPacketType    (rPacketType),
      .rChosenCH      (rChosenCH),
      .rHopsFromCH    (rHopsFromCH),
      .tx             (txIf),
      .busy           (busy),
      .sent           (sent),
      .drop           (drop),
      .dbgState       (dbgState)
   );

   // Clock
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Scoreboard: expected words/last flags, observed words/last flags
   logic [15:0] expQ[$];
   logic        expLastQ[$];
   logic [15:0] obsQ[$];
   logic        obsLastQ[$];
   int          pktStart;

   // Monitor statistics
   int          cycIdx, validCycles, sentCnt, dropCnt, stallErr, idleBusyCycles, firstValidCyc;
   logic        busySeen;
   int          readyMode;
   logic        prevStall, prevLast;
   logic [15:0] prevData;

   function automatic void pushWord(input logic [15:0] w);
      expQ.push_back(w);
      expLastQ.push_back(1'b0);
   endfunction

   function automatic void closePacket();
      logic [15:0] x;
      x = '0;
      for (int i = pktStart; i < expQ.size(); i++) x = x ^ expQ[i];
      if (CS == 1) pushWord(x);
      expLastQ[expLastQ.size()-1] = 1'b1;
      pktStart = expQ.size();
   endfunction

   task automatic clearMon();
      expQ.delete(); expLastQ.delete(); obsQ.delete(); obsLastQ.delete();
      pktStart = 0; cycIdx = 0; validCycles = 0; sentCnt = 0; dropCnt = 0;
      stallErr = 0; idleBusyCycles = 0; firstValidCyc = -1; busySeen = 1'b0;
      prevStall = 1'b0; prevLast = 1'b0; prevData = '0;
   endtask

   // Driver: present one reward result for the next rising edge.
   task automatic driveCapture(input logic [2:0] t, input logic [15:0] src, input logic [15:0] energy,
                               input logic [15:0] q, input logic [15:0] hops, input logic [15:0] dst,
                               input logic [15:0] ch, input logic [15:0] hch);
      rPacketType = t; rSourceID = src; rEnergyLeft = energy; rQValue = q;
      rSourceHops = hops; rDestinationID = dst; rChosenCH = ch; rHopsFromCH = hch;
      reward_done = 1'b1;
   endtask

   // Driver + monitor: runs n cycles, sampling at each falling edge.
   task automatic runCycles(input int n);
      for (int c = 0; c < n; c++) begin
         case (readyMode)
            0:       txIf.tx_ready = 1'b1;
            1:       txIf.tx_ready = (cycIdx % 2 == 0);
            default: txIf.tx_ready = 1'b0;
         endcase
         if (prevStall) begin
            if (!txIf.tx_valid || txIf.tx_data !== prevData || txIf.tx_last !== prevLast) stallErr++;
         end
         prevStall = txIf.tx_valid && !txIf.tx_ready;
         prevData  = txIf.tx_data;
         prevLast  = txIf.tx_last;
         if (txIf.tx_valid) begin
            validCycles++;
            if (firstValidCyc < 0) firstValidCyc = cycIdx;
            if (txIf.tx_ready) begin
               obsQ.push_back(txIf.tx_data);
               obsLastQ.push_back(txIf.tx_last);
            end
         end else if (busy) begin
            idleBusyCycles++;
         end
         if (busy) busySeen = 1'b1;
         if (sent) sentCnt++;
         if (drop) dropCnt++;
         cycIdx++;
         @(negedge clk);
         reward_done = 1'b0;
      end
   endtask

   task automatic test_reset();
      nrst = 1'b1; en = 1'b0; reward_done = 1'b0; txIf.tx_ready = 1'b0;
      rPacketType = '0; rSourceID = '0; rEnergyLeft = '0; rQValue = '0;
      rSourceHops = '0; rDestinationID = '0; rChosenCH = '0; rHopsFromCH = '0;
      #2 nrst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (txIf.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", txIf.tx_valid); end
      checks++; if (txIf.tx_data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h want 0000", txIf.tx_data); end
      checks++; if (txIf.tx_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", txIf.tx_last); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (sent !== 1'b0 || drop !== 1'b0) begin errors++; $display("FAIL rst_pulses: sent %b drop %b want 0 0", sent, drop); end
      checks++; if (dbgState !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want IDLE", dbgState); end
      nrst = 1'b1;
      @(negedge clk);
      checks++; if (txIf.tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_release: valid %b busy %b want 0 0", txIf.tx_valid, busy); end
   endtask

   task automatic test_hb();
      clearMon(); readyMode = 0; en = 1'b1;
      pushWord(CS == 1 ? 16'h2700 : 16'h2600); pushWord(16'h000C); pushWord(16'hFFFF);
      pushWord(16'h0001); pushWord(16'h0000); pushWord(16'h8000); closePacket();
      driveCapture(PKT_HB, 16'h000C, 16'h8000, 16'h0000, 16'h0001, 16'h1234, 16'h5555, 16'h0007);
      runCycles(14);
      checks++; if (firstValidCyc !== 1) begin errors++; $display("FAIL hb_latency: got %0d want 1", firstValidCyc); end
      checks++; if (obsQ.size() !== expQ.size()) begin errors++; $display("FAIL hb_count: got %0d want %0d", obsQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size(); i++) begin
         checks++;
         if (i >= obsQ.size()) begin errors++; $display("FAIL hb_word%0d: missing, want %h", i, expQ[i]); end
         else if (obsQ[i] !== expQ[i] || obsLastQ[i] !== expLastQ[i]) begin
            errors++; $display("FAIL hb_word%0d: got %h last %b want %h last %b", i, obsQ[i], obsLastQ[i], expQ[i], expLastQ[i]);
         end
      end
      checks++; if (sentCnt !== 1) begin errors++; $display("FAIL hb_sent: got %0d want 1", sentCnt); end
      checks++; if (dropCnt !== 0) begin errors++; $display("FAIL hb_drop: got %0d want 0", dropCnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hb_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_che_stall();
      clearMon(); readyMode = 1; en = 1'b1;
      pushWord(CS == 1 ? 16'h4900 : 16'h4800); pushWord(16'h0011); pushWord(16'h0022); pushWord(16'h0003);
      pushWord(16'h0044); pushWord(16'h0055); pushWord(16'h0066); pushWord(16'h0002); closePacket();
      driveCapture(PKT_CHE, 16'h0011, 16'h0055, 16'h0044, 16'h0003, 16'h0022, 16'h0066, 16'h0002);
      runCycles(30);
      checks++; if (stallErr !== 0) begin errors++; $display("FAIL che_stall_stable: got %0d changes want 0", stallErr); end
      checks++; if (obsQ.size() !== expQ.size()) begin errors++; $display("FAIL che_count: got %0d want %0d", obsQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size(); i++) begin
         checks++;
         if (i >= obsQ.size()) begin errors++; $display("FAIL che_word%0d: missing, want %h", i, expQ[i]); end
         else if (obsQ[i] !== expQ[i] || obsLastQ[i] !== expLastQ[i]) begin
            errors++; $display("FAIL che_word%0d: got %h last %b want %h last %b", i, obsQ[i], obsLastQ[i], expQ[i], expLastQ[i]);
         end
      end
      checks++; if (sentCnt !== 1) begin errors++; $display("FAIL che_sent: got %0d want 1", sentCnt); end
   endtask

   task automatic test_back_to_back();
      clearMon(); readyMode = 0; en = 1'b1;
      pushWord(CS == 1 ? 16'h6600 : 16'h6500); pushWord(16'h0101); pushWord(16'h0A0A);
      pushWord(16'h0033); pushWord(16'h7777); closePacket();
      pushWord(CS == 1 ? 16'h8700 : 16'h8600); pushWord(16'h0202); pushWord(16'h0B0B);
      pushWord(16'h0004); pushWord(16'h0055); pushWord(16'h1234); closePacket();
      driveCapture(PKT_MR, 16'h0101, 16'h7777, 16'h0033, 16'h0009, 16'h0F0F, 16'h0A0A, 16'h0008);
      runCycles(2);
      driveCapture(PKT_DATA, 16'h0202, 16'h1234, 16'h0055, 16'h0006, 16'h0B0B, 16'h0C0C, 16'h0004);
      runCycles(25);
      checks++; if (obsQ.size() !== expQ.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", obsQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size(); i++) begin
         checks++;
         if (i >= obsQ.size()) begin errors++; $display("FAIL b2b_word%0d: missing, want %h", i, expQ[i]); end
         else if (obsQ[i] !== expQ[i] || obsLastQ[i] !== expLastQ[i]) begin
            errors++; $display("FAIL b2b_word%0d: got %h last %b want %h last %b", i, obsQ[i], obsLastQ[i], expQ[i], expLastQ[i]);
         end
      end
      checks++; if (idleBusyCycles !== 1) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles want 1", idleBusyCycles); end
      checks++; if (dropCnt !== 0) begin errors++; $display("FAIL b2b_drop: got %0d want 0", dropCnt); end
      checks++; if (sentCnt !== 2) begin errors++; $display("FAIL b2b_sent: got %0d want 2", sentCnt); end
   endtask

   task automatic test_pending_full();
      clearMon(); readyMode = 2; en = 1'b1;
      pushWord(CS == 1 ? 16'h2700 : 16'h2600); pushWord(16'h00A1); pushWord(16'hFFFF);
      pushWord(16'h0002); pushWord(16'h0011); pushWord(16'h0A00); closePacket();
      pushWord(CS == 1 ? 16'h6600 : 16'h6500); pushWord(16'h00B2); pushWord(16'h00C3);
      pushWord(16'h0022); pushWord(16'h0B00); closePacket();
      driveCapture(PKT_HB, 16'h00A1, 16'h0A00, 16'h0011, 16'h0002, 16'h0001, 16'h0003, 16'h0004);
      runCycles(2);
      driveCapture(PKT_MR, 16'h00B2, 16'h0B00, 16'h0022, 16'h0005, 16'h0006, 16'h00C3, 16'h0007);
      runCycles(2);
      driveCapture(PKT_DATA, 16'h00D4, 16'h0C00, 16'h0033, 16'h0008, 16'h0009, 16'h000A, 16'h000B);
      runCycles(2);
      readyMode = 0;
      runCycles(30);
      checks++; if (obsQ.size() !== expQ.size()) begin errors++; $display("FAIL pend_count: got %0d want %0d", obsQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size(); i++) begin
         checks++;
         if (i >= obsQ.size()) begin errors++; $display("FAIL pend_word%0d: missing, want %h", i, expQ[i]); end
         else if (obsQ[i] !== expQ[i] || obsLastQ[i] !== expLastQ[i]) begin
            errors++; $display("FAIL pend_word%0d: got %h last %b want %h last %b", i, obsQ[i], obsLastQ[i], expQ[i], expLastQ[i]);
         end
      end
      checks++; if (dropCnt !== 1) begin errors++; $display("FAIL pend_drop: got %0d want 1", dropCnt); end
      checks++; if (sentCnt !== 2) begin errors++; $display("FAIL pend_sent: got %0d want 2", sentCnt); end
      checks++; if (stallErr !== 0) begin errors++; $display("FAIL pend_stall_stable: got %0d want 0", stallErr); end
   endtask

   task automatic test_ignored();
      clearMon(); readyMode = 0; en = 1'b1;
      driveCapture(3'd6, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007);
      runCycles(6);
      checks++; if (validCycles !== 0) begin errors++; $display("FAIL badtype_valid: got %0d valid cycles want 0", validCycles); end
      checks++; if (dropCnt !== 1) begin errors++; $display("FAIL badtype_drop: got %0d want 1", dropCnt); end
      checks++; if (busySeen !== 1'b0) begin errors++; $display("FAIL badtype_busy: got %b want 0", busySeen); end
      clearMon(); en = 1'b0;
      driveCapture(PKT_HB, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007);
      runCycles(6);
      checks++; if (validCycles !== 0) begin errors++; $display("FAIL en_low_valid: got %0d valid cycles want 0", validCycles); end
      checks++; if (dropCnt !== 0) begin errors++; $display("FAIL en_low_drop: got %0d want 0", dropCnt); end
      checks++; if (busySeen !== 1'b0) begin errors++; $display("FAIL en_low_busy: got %b want 0", busySeen); end
      en = 1'b1;
   endtask

   task automatic test_reset_mid();
      clearMon(); readyMode = 0; en = 1'b1;
      driveCapture(PKT_CHE, 16'h0011, 16'h0055, 16'h0044, 16'h0003, 16'h0022, 16'h0066, 16'h0002);
      runCycles(2);
      driveCapture(PKT_MR, 16'h0101, 16'h7777, 16'h0033, 16'h0009, 16'h0F0F, 16'h0A0A, 16'h0008);
      runCycles(1);
      checks++; if (txIf.tx_valid !== 1'b1 || txIf.tx_data !== 16'h0022) begin
         errors++; $display("FAIL mid_third_word: valid %b data %h want 1 0022", txIf.tx_valid, txIf.tx_data);
      end
      #2 nrst = 1'b0;
      #1;
      checks++; if (txIf.tx_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b want 0", txIf.tx_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy: got %b want 0", busy); end
      checks++; if (dbgState !== IDLE) begin errors++; $display("FAIL mid_async_state: got %0d want IDLE", dbgState); end
      @(negedge clk);
      nrst = 1'b1;
      clearMon();
      runCycles(20);
      checks++; if (validCycles !== 0) begin errors++; $display("FAIL mid_residual: got %0d valid cycles want 0", validCycles); end
      checks++; if (sentCnt !== 0 || busySeen !== 1'b0) begin
         errors++; $display("FAIL mid_pending: sent %0d busy %b want 0 0", sentCnt, busySeen);
      end
   endtask

   initial begin
      test_reset();
      test_hb();
      test_che_stall();
      test_back_to_back();
      test_pending_full();
      test_ignored();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/packet_assembler.md
Name: packet_assembler

Overview:
- Sits directly downstream of the reward stage in the EER-RL node datapath.
- Captures the reward stage's outgoing-packet fields on its done pulse and formats them into a type-dependent sequence of 16-bit words.
- Streams those words to the radio/TX message buffer over a valid/ready interface.
- Provides one-deep pending storage so a back-to-back reward result is not lost while a packet is still draining.

Parameters:
- WORD_WIDTH, 16, width of every packet field and TX word
- BCAST_ID, 16'hFFFF, destination ID forced for heartbeat packets
- MAX_WORDS, 9, upper bound on words per packet, including the optional checksum

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  capture enable; reward_done is ignored while low
- reward_done  in  1  one-cycle pulse from the reward stage: fields below are valid
- rSourceID  in  16  source node ID
- rEnergyLeft  in  16  residual energy
- rQValue  in  16  Q-value
- rSourceHops  in  16  hops from sink
- rDestinationID  in  16  next hop / destination
- rPacketType  in  3  packet type
- rChosenCH  in  16  chosen cluster head
- rHopsFromCH  in  16  hops to cluster head
- tx_ready  in  1  downstream accepts tx_data this cycle
- tx_valid  out  1  tx_data valid
- tx_data  out  16  packet word
- tx_last  out  1  final word of the packet
- busy  out  1  a packet is being sent or is pending
- sent  out  1  one-cycle pulse after the last word's handshake
- drop  out  1  one-cycle pulse when a capture is discarded

Behaviour:
- Reset: tx_valid, tx_last, busy, sent and drop are 0; tx_data is 0; FSM is in IDLE; pending slot is empty.
- Capture: when en && reward_done, all fields are registered.
- Header word 0 is {rPacketType, LEN[4:0], 8'h00}, where LEN is the total word count.
- Word layouts by type:
  - HB (3'd1), 6 words: hdr, src, BCAST_ID, hops, Q, energy
  - CHE (3'd2), 8 words: hdr, src, dst, hops, Q, energy, chosenCH, hopsFromCH
  - MR (3'd3), 5 words: hdr, src, chosenCH, Q, energy
  - DATA (3'd4), 6 words: hdr, src, dst, hopsFromCH, Q, energy
  - Types 0, 5, 6, 7 are not captured: drop pulses in the following cycle and state is unchanged.
- FSM states: IDLE, SEND.
  - IDLE → SEND on a valid capture. tx_valid rises the cycle after reward_done, carrying word 0 (latency 1).
  - In SEND, the word index advances only on tx_valid && tx_ready.
  - While tx_ready is low, tx_data and tx_last hold stable and tx_valid stays high. tx_valid never drops mid-packet.
  - tx_last is high exactly on word LEN-1.
  - On the handshake of the last word, sent pulses the next cycle. If the pending slot is full, its contents move to the active register and word 0 of that packet is presented in the next cycle (one idle cycle between packets; tx_valid is 0 in that cycle). Otherwise the FSM returns to IDLE.
- Capture while in SEND: the fields go to the pending slot.
  - If the pending slot is already full, the new capture is dropped (drop pulses) and the existing pending packet is kept.
  - A capture in the same cycle as the last-word handshake goes to the pending slot.
- busy = (state == SEND) || pending slot full.
- en low mid-packet does not stop transmission; it only blocks new captures.
- Reset mid-packet aborts immediately: tx_valid goes to 0 asynchronously and the pending slot is cleared.

Optional Feature:
- Macro: PKT_CHECKSUM_EN.
- When defined:
  - An extra final word is appended, equal to the XOR of all preceding words including the header.
  - LEN in the header counts this word.
  - tx_last moves to the checksum word.
- When undefined: packets are exactly as listed in Behaviour, and no checksum logic is present.

Decomposition:
- Shared package (eer_pkt_pkg) holds:
  - packet-type constants PKT_HB, PKT_CHE, PKT_MR, PKT_DATA
  - the per-type length constants
  - the FSM state enum
  - a packed struct of the eight captured fields (used for both the active register and the pending slot)
- One sub-module, pkt_word_mux: combinational selection of the word for (type, index), plus the LEN lookup.

Test Plan:
- HB with rSourceID=16'h000C, rSourceHops=1, rQValue=0, rEnergyLeft=16'h8000, tx_ready=1 → words 16'h2600, 000C, FFFF, 0001, 0000, 8000; tx_last on the 6th word; sent pulses once.
- CHE with tx_ready toggling 1/0 each cycle → 8 words; tx_data is stable across every stall; the word order is unchanged.
- MR followed two cycles later by DATA, with tx_ready=1 → MR (5 words), then one idle cycle, then DATA (6 words); no drop.
- Three captures during one long-stalled packet → the second is held in pending, the third raises drop=1; exactly two sent pulses occur.
- rPacketType=3'd6, or en=0 during reward_done → no tx_valid; drop=1 for the invalid type only; busy stays 0.
- nrst asserted on the 3rd word of a CHE → tx_valid=0 immediately; after release, no residual or pending packet is emitted.
